// File: rtl/lvds_frame_rx.sv
// DDR I/Q frame receiver: aligns on I/Q sync dibits, assembles tagged sample words
// for the RX FIFO and keeps sync-error, overflow and frame statistics.
module lvds_frame_rx #(
    parameter int SAMPLE_BITS = 14,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                       i_ddr_clk,
    input  logic                       i_reset,
    input  logic [1:0]                 i_ddr_data,
    input  logic                       i_enable,
    input  logic [1:0]                 i_mode,
    input  logic                       i_clear_stats,
    input  logic                       i_fifo_full,
    output logic                       o_fifo_write_clk,
    output logic                       o_fifo_push,
    output logic [2*SAMPLE_BITS+3:0]   o_fifo_data,
    output logic [ERR_CNT_W-1:0]       o_sync_err_cnt,
    output logic [ERR_CNT_W-1:0]       o_overflow_cnt,
    output logic [ERR_CNT_W-1:0]       o_frame_cnt,
    output logic [1:0]                 o_debug_state
);

    localparam int DIBITS = SAMPLE_BITS / 2;
    localparam int CNT_W  = $clog2(DIBITS);
    localparam int WORD_W = 2 * SAMPLE_BITS + 4;
    localparam logic [CNT_W-1:0] LAST_DIBIT = CNT_W'(DIBITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_DATA = 2'd1,
        ST_Q_SYNC = 2'd2,
        ST_Q_DATA = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SAMPLE_BITS-1:0]  i_sr_q, i_sr_d;
    logic [SAMPLE_BITS-1:0]  q_sr_q, q_sr_d;
    logic                    push_q, push_d;
    logic [WORD_W-1:0]       data_q, data_d;
    logic [ERR_CNT_W-1:0]    sync_err_q, sync_err_d;
    logic [ERR_CNT_W-1:0]    ovf_q, ovf_d;
    logic [ERR_CNT_W-1:0]    frame_q, frame_d;

    logic [SAMPLE_BITS-1:0]  frame_pat;
    logic [3:0]              frame_tag;
    logic [SAMPLE_BITS-1:0]  q_full;
    logic [SAMPLE_BITS-1:0]  word_i;
    logic [SAMPLE_BITS-1:0]  word_q;
    logic [3:0]              word_tag;
    logic                    frame_done;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    function automatic logic [SAMPLE_BITS-1:0] shift_in(input logic [SAMPLE_BITS-1:0] sr,
                                                        input logic [1:0] d);
        return {sr[SAMPLE_BITS-3:0], d};
    endfunction

    // Frame counter views, zero-extended when the counter is narrower than the field.
    generate
        if (ERR_CNT_W >= SAMPLE_BITS) begin : g_pat_trunc
            assign frame_pat = frame_q[SAMPLE_BITS-1:0];
        end else begin : g_pat_ext
            assign frame_pat = {{(SAMPLE_BITS-ERR_CNT_W){1'b0}}, frame_q};
        end
        if (ERR_CNT_W >= 4) begin : g_tag_trunc
            assign frame_tag = frame_q[3:0];
        end else begin : g_tag_ext
            assign frame_tag = {{(4-ERR_CNT_W){1'b0}}, frame_q};
        end
    endgenerate

    // The last Q dibit is still on the wire at completion, so the word uses the shifted value.
    assign q_full = shift_in(q_sr_q, i_ddr_data);

    always_comb begin
        word_tag = frame_tag;
        word_i   = i_sr_q;
        word_q   = q_full;
        case (i_mode)
            2'd1: word_tag = 4'b1001;
            2'd2: begin
                word_i = frame_pat;
                word_q = ~frame_pat;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        i_sr_d     = i_sr_q;
        q_sr_d     = q_sr_q;
        push_d     = 1'b0;
        data_d     = data_q;
        sync_err_d = sync_err_q;
        ovf_d      = ovf_q;
        frame_d    = frame_q;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_ddr_data == 2'b10) begin
                    state_d = ST_I_DATA;
                    cnt_d   = '0;
                end
            end
            ST_I_DATA: begin
                i_sr_d = shift_in(i_sr_q, i_ddr_data);
                if (cnt_q == LAST_DIBIT) begin
                    state_d = ST_Q_SYNC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_Q_SYNC: begin
                if (i_ddr_data == 2'b01) begin
                    state_d = ST_Q_DATA;
                    cnt_d   = '0;
                end else begin
                    state_d    = ST_IDLE;
                    sync_err_d = sat_inc(sync_err_q);
                end
            end
            ST_Q_DATA: begin
                q_sr_d = q_full;
                if (cnt_q == LAST_DIBIT) begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_done) begin
            frame_d = frame_q + ERR_CNT_W'(1);
            if (i_enable) begin
                if (!i_fifo_full) begin
                    push_d = 1'b1;
                    data_d = {word_tag[3:2], word_i, word_tag[1:0], word_q};
                end else begin
                    ovf_d = sat_inc(ovf_q);
                end
            end
        end

        if (i_clear_stats) begin
            sync_err_d = '0;
            ovf_d      = '0;
            frame_d    = '0;
        end
    end

    always_ff @(posedge i_ddr_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            i_sr_q     <= '0;
            q_sr_q     <= '0;
            push_q     <= 1'b0;
            data_q     <= '0;
            sync_err_q <= '0;
            ovf_q      <= '0;
            frame_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            i_sr_q     <= i_sr_d;
            q_sr_q     <= q_sr_d;
            push_q     <= push_d;
            data_q     <= data_d;
            sync_err_q <= sync_err_d;
            ovf_q      <= ovf_d;
            frame_q    <= frame_d;
        end
    end

    assign o_fifo_write_clk = i_ddr_clk;
    assign o_fifo_push      = push_q;
    assign o_fifo_data      = data_q;
    assign o_sync_err_cnt   = sync_err_q;
    assign o_overflow_cnt   = ovf_q;
    assign o_frame_cnt      = frame_q;
    assign o_debug_state    = state_q;

endmodule

// File: tb/tb_lvds_frame_rx.sv
// Scoreboard bench for lvds_frame_rx: default instance (14/16) and a narrow
// instance (12/2) for test-pattern mode and counter saturation/wrap.
module tb_lvds_frame_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ddr_a, ddr_b;
    logic        enable, clear, full;
    logic [1:0]  mode;

    logic        wclk_a, push_a;
    logic [31:0] data_a;
    logic [15:0] serr_a, ovf_a, frm_a;
    logic [1:0]  state_a;

    logic        wclk_b, push_b;
    logic [27:0] data_b;
    logic [1:0]  serr_b, ovf_b, frm_b;
    logic [1:0]  state_b;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          sel_b = 1'b0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          pa_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lvds_frame_rx #(.SAMPLE_BITS(14), .ERR_CNT_W(16)) dut_a (
        .i_ddr_clk(clk), .i_reset(rst_n), .i_ddr_data(ddr_a), .i_enable(enable),
        .i_mode(mode), .i_clear_stats(clear), .i_fifo_full(full),
        .o_fifo_write_clk(wclk_a), .o_fifo_push(push_a), .o_fifo_data(data_a),
        .o_sync_err_cnt(serr_a), .o_overflow_cnt(ovf_a), .o_frame_cnt(frm_a),
        .o_debug_state(state_a)
    );

    lvds_frame_rx #(.SAMPLE_BITS(12), .ERR_CNT_W(2)) dut_b (
        .i_ddr_clk(clk), .i_reset(rst_n), .i_ddr_data(ddr_b), .i_enable(enable),
        .i_mode(mode), .i_clear_stats(clear), .i_fifo_full(full),
        .o_fifo_write_clk(wclk_b), .o_fifo_push(push_b), .o_fifo_data(data_b),
        .o_sync_err_cnt(serr_b), .o_overflow_cnt(ovf_b), .o_frame_cnt(frm_b),
        .o_debug_state(state_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every push pops one expected word from that instance's queue.
    always @(negedge clk) begin
        if (push_a === 1'b1) begin
            pa_cyc.push_back(cyc);
            if (qa.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL a_unexpected_push: got data %h expected no push", data_a);
            end else begin
                chk("a_word", data_a, qa.pop_front());
            end
        end
        if (push_b === 1'b1) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL b_unexpected_push: got data %h expected no push", data_b);
            end else begin
                chk("b_word", {4'h0, data_b}, qb.pop_front());
            end
        end
    end

    task automatic sym(input logic [1:0] s);
        if (sel_b) begin
            ddr_b = s;
            ddr_a = 2'b00;
        end else begin
            ddr_a = s;
            ddr_b = 2'b00;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_dibits(input logic [29:0] v, input int nd);
        logic [29:0] t;
        for (int k = 0; k < nd; k++) begin
            t = v >> (2 * (nd - 1 - k));
            sym(t[1:0]);
        end
    endtask

    task automatic send_frame(input logic [29:0] iv, input logic [29:0] qv, input int nd,
                              input logic [1:0] qs, input bit exp_push, input string nm);
        sym(2'b10);
        send_dibits(iv, nd);
        sym(qs);
        if (qs == 2'b01) send_dibits(qv, nd);
        chk(nm, {31'd0, (sel_b ? push_b : push_a)}, {31'd0, exp_push});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ddr_a = 2'b00;
        ddr_b = 2'b00;
        enable = 1'b1;
        clear = 1'b0;
        full = 1'b0;
        mode = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_push", {31'd0, push_a}, 32'd0);
        chk("rst_data", data_a, 32'd0);
        chk("rst_state", {30'd0, state_a}, 32'd0);
        chk("rst_counters", {serr_a, ovf_a}, 32'd0);
        chk("rst_frame", {16'd0, frm_a}, 32'd0);
        rst_n = 1'b1;

        // Two back-to-back frames, mode 0.
        qa.push_back({2'b00, 14'h1ABC, 2'b00, 14'h0123});
        qa.push_back({2'b00, 14'h1ABC, 2'b01, 14'h0123});
        send_frame(30'h1ABC, 30'h0123, 7, 2'b01, 1'b1, "a_push_lat1");
        send_frame(30'h1ABC, 30'h0123, 7, 2'b01, 1'b1, "a_push_lat2");
        sym(2'b00);
        chk("a_frame_cnt2", {16'd0, frm_a}, 32'd2);
        chk("a_push_count2", pa_cyc.size(), 32'd2);
        if (pa_cyc.size() == 2) chk("a_push_spacing", pa_cyc[1] - pa_cyc[0], 32'd16);

        // Bad Q sync, then a frame whose data contains sync-like dibits.
        send_frame(30'h1ABC, 30'h0123, 7, 2'b11, 1'b0, "a_badsync_nopush");
        chk("a_sync_err1", {16'd0, serr_a}, 32'd1);
        chk("a_state_idle", {30'd0, state_a}, 32'd0);
        qa.push_back({2'b00, 14'h2AAA, 2'b10, 14'h1555});
        send_frame(30'h2AAA, 30'h1555, 7, 2'b01, 1'b1, "a_after_err_push");
        chk("a_frame_cnt3", {16'd0, frm_a}, 32'd3);

        // FIFO full, then disabled with FIFO full.
        full = 1'b1;
        send_frame(30'h0F0F, 30'h3030, 7, 2'b01, 1'b0, "a_full_nopush");
        chk("a_ovf1", {16'd0, ovf_a}, 32'd1);
        chk("a_frame_cnt4", {16'd0, frm_a}, 32'd4);
        enable = 1'b0;
        send_frame(30'h0F0F, 30'h3030, 7, 2'b01, 1'b0, "a_dis_nopush");
        chk("a_ovf_hold", {16'd0, ovf_a}, 32'd1);
        chk("a_frame_cnt5", {16'd0, frm_a}, 32'd5);
        enable = 1'b1;
        full = 1'b0;

        // Mode 1 sync tag, mode 3 behaves as frame-count tag.
        mode = 2'd1;
        qa.push_back({2'b10, 14'h0001, 2'b01, 14'h2000});
        send_frame(30'h0001, 30'h2000, 7, 2'b01, 1'b1, "a_mode1_push");
        mode = 2'd3;
        qa.push_back({2'b01, 14'h3C3C, 2'b10, 14'h0FF0});
        send_frame(30'h3C3C, 30'h0FF0, 7, 2'b01, 1'b1, "a_mode3_push");
        chk("a_frame_cnt7", {16'd0, frm_a}, 32'd7);

        // Reset in the middle of Q_DATA.
        mode = 2'd0;
        sym(2'b10);
        send_dibits(30'h1111, 7);
        sym(2'b01);
        send_dibits(30'h0007, 3);
        chk("a_pre_rst_state", {30'd0, state_a}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("a_rst_push", {31'd0, push_a}, 32'd0);
        chk("a_rst_data", data_a, 32'd0);
        chk("a_rst_cnts", {serr_a, ovf_a}, 32'd0);
        chk("a_rst_frame", {16'd0, frm_a}, 32'd0);
        chk("a_rst_state", {30'd0, state_a}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        qa.push_back({2'b00, 14'h1234, 2'b00, 14'h3456});
        send_frame(30'h1234, 30'h3456, 7, 2'b01, 1'b1, "a_post_rst_push");
        sym(2'b00);

        // Narrow instance: test pattern mode.
        sel_b = 1'b1;
        mode = 2'd2;
        qb.push_back({4'h0, 2'b00, 12'h000, 2'b00, 12'hFFF});
        qb.push_back({4'h0, 2'b00, 12'h001, 2'b01, 12'hFFE});
        qb.push_back({4'h0, 2'b00, 12'h002, 2'b10, 12'hFFD});
        send_frame(30'hABC, 30'h123, 6, 2'b01, 1'b1, "b_pat_push0");
        send_frame(30'h555, 30'hAAA, 6, 2'b01, 1'b1, "b_pat_push1");
        send_frame(30'hFFF, 30'h000, 6, 2'b01, 1'b1, "b_pat_push2");
        chk("b_frame_cnt3", {30'd0, frm_b}, 32'd3);

        clear = 1'b1;
        sym(2'b00);
        clear = 1'b0;
        chk("b_clear_frame", {30'd0, frm_b}, 32'd0);

        // Sync-error saturation, then clear coinciding with another error.
        for (int f = 0; f < 5; f++) begin
            send_frame(30'h3A5, 30'h0, 6, 2'b11, 1'b0, "b_bad_nopush");
            if (f == 2) chk("b_serr_at3", {30'd0, serr_b}, 32'd3);
        end
        chk("b_serr_sat", {30'd0, serr_b}, 32'd3);
        chk("b_state_idle", {30'd0, state_b}, 32'd0);
        sym(2'b10);
        send_dibits(30'h3A5, 6);
        clear = 1'b1;
        sym(2'b11);
        clear = 1'b0;
        chk("b_serr_clear_prio", {30'd0, serr_b}, 32'd0);

        // Overflow saturation and frame counter wrap.
        mode = 2'd0;
        full = 1'b1;
        for (int f = 0; f < 4; f++)
            send_frame(30'h0C3, 30'h3C0, 6, 2'b01, 1'b0, "b_full_nopush");
        chk("b_ovf_sat", {30'd0, ovf_b}, 32'd3);
        chk("b_frame_wrap", {30'd0, frm_b}, 32'd0);
        full = 1'b0;
        qb.push_back({4'h0, 2'b00, 12'h9A5, 2'b00, 12'h5A9});
        send_frame(30'h9A5, 30'h5A9, 6, 2'b01, 1'b1, "b_wrap_push");
        sym(2'b00);
        sym(2'b00);

        chk("a_queue_drained", qa.size(), 32'd0);
        chk("b_queue_drained", qb.size(), 32'd0);
        chk("a_total_pushes", pa_cyc.size(), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
